gpr_seq_capture: RTL and testbench
==================================

# gpr_seq_capture

Receive-side counterpart of the GPR sequencer. It accepts a stream of data words over a valid/ready handshake and writes them in order into an `ADDR_COUNT`-entry register file, wrapping every frame of `ADDR_COUNT` words. Each word is checked against the sequencer's reset pattern (word k = k+1), and the block reports a per-frame verdict. The captured contents are readable through a registered read port. It sits in the lab1 datapath downstream of the sequencer's `o_data`.

## Interface
- `ADDR_WIDTH`, 2, register-file address width; also the width of the write pointer.
- `ADDR_COUNT`, `1 << ADDR_WIDTH`, number of entries and words per frame.
- `DATA_WIDTH`, 32, data word width.

- `i_clk` input 1: single clock; all logic on the rising edge.
- `i_rst_n` input 1: reset, synchronous, active-low.
- `i_valid` input 1: `i_data` is valid this cycle.
- `o_ready` output 1: the block accepts a word this cycle. A word transfers on any edge where `i_valid && o_ready`.
- `i_data` input `DATA_WIDTH`: incoming word.
- `i_raddr` input `ADDR_WIDTH`: read-port address.
- `o_rdata` output `DATA_WIDTH`: registered read data.
- `o_frame_done` output 1: one-cycle pulse after the last word of a frame is accepted.
- `o_match` output 1: 1 when the most recent completed frame had zero mismatches.
- `o_err_cnt` output `ADDR_WIDTH+1`: mismatch count of the most recent completed frame (0..`ADDR_COUNT`).
- `o_frame_cnt` output 8: number of completed frames, wraps modulo 256.

## Operation
- **States**
  - FILL: accepting words; `o_ready` = 1.
  - DONE: frame-boundary bubble; `o_ready` = 0.
  - `o_ready` is decoded directly from the state (FILL).
- **Internal state**
  - `wptr` (`ADDR_WIDTH` bits): write pointer.
  - `acc_err` (`ADDR_WIDTH+1` bits): running mismatch count.
  - `gpr[0..ADDR_COUNT-1]`: register file.
- **On each accepted word in FILL**
  - `gpr[wptr]` <= `i_data`.
  - The word mismatches when `i_data != wptr + 1`, with `wptr + 1` computed at `DATA_WIDTH` width and zero-extended (no truncation at `wptr = ADDR_COUNT-1`).
  - Not last word (`wptr != ADDR_COUNT-1`): `wptr` increments and `acc_err` adds 1 on mismatch.
  - Last word (`wptr == ADDR_COUNT-1`):
    - `wptr` <= 0 and state <= DONE.
    - `o_err_cnt` <= `acc_err` + (mismatch of this word).
    - `o_match` <= (that sum == 0).
    - `o_frame_done` <= 1.
    - `o_frame_cnt` increments.
    - `acc_err` <= 0.
- **DONE:** lasts exactly one cycle, then returns to FILL unconditionally. `o_frame_done` <= 0 on the exit edge. No word is accepted in DONE; a held `i_valid`/`i_data` is accepted on the next cycle as word 0 of the new frame.
- **No valid:** when `i_valid` = 0 in FILL, nothing changes.
- **Read port:** `o_rdata` <= `gpr[i_raddr]` on every non-reset edge, independent of state and handshake.
- **Reset** (`!i_rst_n` at an edge):
  - state = FILL, `wptr` = 0, `acc_err` = 0, all `gpr` entries = 0.
  - `o_rdata` = 0, `o_frame_done` = 0, `o_match` = 0, `o_err_cnt` = 0, `o_frame_cnt` = 0.
  - Reset has priority over handshake and read.
  - A partial frame at reset is discarded, with no `o_frame_done`.

## Timing
- **Write-to-read latency:** a word accepted at edge t is written at t. With `i_raddr` pointing at it during cycle t..t+1, `o_rdata` shows it after edge t+1.
- **Same-cycle write and read of one address:** `o_rdata` returns the old contents (read-before-write).
- **Frame boundary** (last word accepted at edge t):
  - `o_frame_done`, `o_match`, `o_err_cnt` and `o_frame_cnt` update at t.
  - `o_ready` is 0 for cycle t..t+1 and is 1 again after edge t+1.
- **Throughput:** a frame takes a minimum of `ADDR_COUNT`+1 cycles (one bubble per frame).
- **Verdict holding:** `o_match` and `o_err_cnt` hold their values until the next frame completes or reset.
- **Wrap-around:** `wptr` wraps from `ADDR_COUNT-1` to 0. `o_frame_cnt` wraps from 255 to 0.

## Test plan
- **Clean frame.** Reset, then drive `i_valid` = 1 continuously with data 1,2,3,4 (defaults), each word presented until accepted. Required response:
  - `o_frame_done` pulses once, in the cycle after the 4th accept, with `o_ready` = 0 in that cycle.
  - `o_match` = 1, `o_err_cnt` = 0, `o_frame_cnt` = 1.
  - Reading `i_raddr` 0..3 returns 1,2,3,4.
- **Mismatches.** Send words 1,9,3,0.
  - Required: `o_err_cnt` = 2, `o_match` = 0, and `i_raddr` = 1 reads 9.
  - Follow with a clean 1,2,3,4 frame; required: `o_match` returns to 1 and `o_err_cnt` returns to 0.
- **Gapped valid.** Toggle `i_valid` 1,0,0,1,0,1,1 with data 1,x,x,2,x,3,4.
  - Required: only handshaken words are written, and `o_frame_done` pulses after the word 4 accept.
- **Held valid across DONE.** Keep `i_valid` = 1 with `i_data` = 1 through the DONE cycle.
  - Required: the word is not accepted in DONE, and is accepted on the next edge as word 0 (`gpr[0]` = 1).
- **Mid-frame reset.** Accept 1,2, then assert `i_rst_n` = 0 for one cycle.
  - Required: no `o_frame_done`, all outputs 0, `gpr[0..1]` reads 0.
  - Then send 1,2,3,4; required: a clean frame with `o_frame_cnt` = 1.
- **Counter wrap.** Send 256 clean frames.
  - Required: `o_frame_cnt` goes 255 → 0, with exactly 256 `o_frame_done` pulses.

Source files
------------

// File: rtl/gpr_seq_capture.sv
// gpr_seq_capture: receive-side counterpart of the GPR sequencer.
// Captures a valid/ready word stream into a small register file, one frame
// of ADDR_COUNT words at a time. Each word is checked against the
// sequencer's reset pattern (word k = k+1), and a per-frame verdict is
// reported. One bubble cycle (DONE) separates consecutive frames.
module gpr_seq_capture #(
  parameter int ADDR_WIDTH = 2,
  parameter int ADDR_COUNT = 1 << ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_frame_done,
  output logic                  o_match,
  output logic [ADDR_WIDTH:0]   o_err_cnt,
  output logic [7:0]            o_frame_cnt
);

  typedef enum logic {
    FILL = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_COUNT - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wptr;
  logic [ADDR_WIDTH:0]     acc_err;
  logic [DATA_WIDTH-1:0]   gpr [ADDR_COUNT];

  logic [DATA_WIDTH-1:0]   expected_word;
  logic                    mismatch;
  logic [ADDR_WIDTH:0]     frame_err;

  // Ready is a pure decode of the state: the block only takes words in FILL.
  assign o_ready = (state == FILL);

  // Reference pattern is computed at full data width so the last word of a
  // frame compares against ADDR_COUNT rather than a truncated zero.
  assign expected_word = DATA_WIDTH'(wptr) + DATA_WIDTH'(1);
  assign mismatch      = (i_data != expected_word);
  assign frame_err     = acc_err + (ADDR_WIDTH + 1)'(mismatch);

  // Handshake FSM, register file write, frame verdict and read port.
  // NOTE: all state here uses non-blocking assignments, so the read of
  // gpr[i_raddr] sees the value from before this edge's write
  // (read-before-write on a same-address collision).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= FILL;
      wptr         <= '0;
      acc_err      <= '0;
      // NOTE: the register file is cleared on reset so a partial frame is
      // discarded and reads after reset return zero; this keeps the entries
      // in flops rather than a RAM macro, which is fine at this size.
      for (int i = 0; i < ADDR_COUNT; i++) begin
        gpr[i] <= '0;
      end
      o_rdata      <= '0;
      o_frame_done <= 1'b0;
      o_match      <= 1'b0;
      o_err_cnt    <= '0;
      o_frame_cnt  <= '0;
    end else begin
      o_rdata <= gpr[i_raddr];

      case (state)
        FILL: begin
          if (i_valid) begin
            gpr[wptr] <= i_data;
            if (wptr == LAST_ADDR) begin
              wptr         <= '0;
              state        <= DONE;
              o_err_cnt    <= frame_err;
              o_match      <= (frame_err == '0);
              o_frame_done <= 1'b1;
              o_frame_cnt  <= o_frame_cnt + 8'd1;
              acc_err      <= '0;
            end else begin
              wptr    <= wptr + ADDR_WIDTH'(1);
              acc_err <= frame_err;
            end
          end
        end

        DONE: begin
          // Single bubble cycle; a held word is taken on the next edge.
          state        <= FILL;
          o_frame_done <= 1'b0;
        end

        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpr_seq_capture.sv
// Self-checking bench for gpr_seq_capture. A cycle-level reference model
// tracks ready, the write pointer and the register file; frame verdicts are
// pushed to a scoreboard queue when the last word is accepted and popped by
// a monitor when o_frame_done pulses.
module tb_gpr_seq_capture;

  localparam int AW = 2;
  localparam int AC = 1 << AW;
  localparam int DW = 32;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic [AW-1:0] i_raddr;
  logic [DW-1:0] o_rdata;
  logic          o_frame_done;
  logic          o_match;
  logic [AW:0]   o_err_cnt;
  logic [7:0]    o_frame_cnt;

  gpr_seq_capture #(
    .ADDR_WIDTH(AW),
    .ADDR_COUNT(AC),
    .DATA_WIDTH(DW)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
    .i_raddr      (i_raddr),
    .o_rdata      (o_rdata),
    .o_frame_done (o_frame_done),
    .o_match      (o_match),
    .o_err_cnt    (o_err_cnt),
    .o_frame_cnt  (o_frame_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [AW:0] err;
    logic        match;
    logic [7:0]  fcnt;
  } verdict_t;

  verdict_t sb[$];
  verdict_t mon_v;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] m_mem [AC];
  int            m_wptr;
  int            m_acc;
  bit            m_done;
  logic [7:0]    m_fcnt;

  // Monitor bookkeeping
  int         pulses = 0;
  logic [7:0] prev_fcnt = 8'd0;
  bit         saw_wrap = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < AC; i++) m_mem[i] = '0;
    m_wptr = 0;
    m_acc  = 0;
    m_done = 1'b0;
    m_fcnt = 8'd0;
    prev_fcnt = 8'd0;
  endtask

  // One clock cycle of stimulus: drive, sample ready at the falling edge,
  // advance the model after the rising edge.
  task automatic drive_cycle(input bit v, input logic [DW-1:0] d);
    bit acc;
    i_valid = v;
    i_data  = d;
    @(negedge i_clk);
    checks++;
    if (o_ready !== !m_done) begin
      errors++;
      $display("FAIL ready: got %b expected %b (t=%0t)", o_ready, !m_done, $time);
    end
    acc = v && !m_done;
    @(posedge i_clk);
    #1;
    if (m_done) begin
      m_done = 1'b0;
    end else if (acc) begin
      m_mem[m_wptr] = d;
      if (d != DW'(m_wptr + 1)) m_acc++;
      if (m_wptr == AC - 1) begin
        m_fcnt = m_fcnt + 8'd1;
        sb.push_back('{err: (AW + 1)'(m_acc), match: (m_acc == 0), fcnt: m_fcnt});
        m_wptr = 0;
        m_acc  = 0;
        m_done = 1'b1;
      end else begin
        m_wptr++;
      end
    end
  endtask

  // Present a word with valid held until accepted (at most one bubble).
  task automatic send_word(input logic [DW-1:0] d);
    if (m_done) drive_cycle(1'b1, d);
    drive_cycle(1'b1, d);
  endtask

  task automatic send_frame(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] c, input logic [DW-1:0] e);
    send_word(a);
    send_word(b);
    send_word(c);
    send_word(e);
    i_valid = 1'b0;
  endtask

  task automatic read_check(input logic [AW-1:0] addr, input logic [DW-1:0] exp,
                            input string name);
    i_raddr = addr;
    drive_cycle(1'b0, 32'hDEAD_BEEF);
    checks++;
    if (o_rdata !== exp) begin
      errors++;
      $display("FAIL %s: rdata[%0d] got %h expected %h", name, addr, o_rdata, exp);
    end
  endtask

  task automatic check_verdict(input logic exp_match, input logic [AW:0] exp_err,
                               input logic [7:0] exp_fcnt, input string name);
    checks++;
    if (o_match !== exp_match || o_err_cnt !== exp_err || o_frame_cnt !== exp_fcnt) begin
      errors++;
      $display("FAIL %s: match/err/fcnt got %b/%0d/%0d expected %b/%0d/%0d", name,
               o_match, o_err_cnt, o_frame_cnt, exp_match, exp_err, exp_fcnt);
    end
  endtask

  task automatic apply_reset(input int cycles);
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    repeat (cycles) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (o_rdata !== '0 || o_frame_done !== 1'b0 || o_match !== 1'b0 ||
        o_err_cnt !== '0 || o_frame_cnt !== 8'd0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: rdata=%h done=%b match=%b err=%0d fcnt=%0d ready=%b expected zeros, ready=1",
               name, o_rdata, o_frame_done, o_match, o_err_cnt, o_frame_cnt, o_ready);
    end
  endtask

  // Frame-verdict monitor: every o_frame_done pulse must match a queued verdict.
  always @(negedge i_clk) begin
    if (i_rst_n === 1'b1 && o_frame_done === 1'b1) begin
      pulses++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL frame_done_unexpected: pulse with empty scoreboard (t=%0t)", $time);
      end else begin
        mon_v = sb.pop_front();
        if (o_err_cnt !== mon_v.err || o_match !== mon_v.match ||
            o_frame_cnt !== mon_v.fcnt || o_ready !== 1'b0) begin
          errors++;
          $display("FAIL frame_verdict: err/match/fcnt/ready got %0d/%b/%0d/%b expected %0d/%b/%0d/0",
                   o_err_cnt, o_match, o_frame_cnt, o_ready,
                   mon_v.err, mon_v.match, mon_v.fcnt);
        end
        if (prev_fcnt == 8'd255 && o_frame_cnt == 8'd0) saw_wrap = 1'b1;
        prev_fcnt = o_frame_cnt;
      end
    end
  end

  task automatic test_reset();
    apply_reset(2);
    check_all_zero("reset_state");
    read_check(2'd3, 32'd0, "reset_gpr3");
  endtask

  task automatic test_clean();
    send_frame(1, 2, 3, 4);
    checks++;
    if (o_frame_done !== 1'b1 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL clean_done_pulse: done=%b ready=%b expected 1/0", o_frame_done, o_ready);
    end
    check_verdict(1'b1, 3'd0, 8'd1, "clean_verdict");
    drive_cycle(1'b0, 32'd0);
    checks++;
    if (o_frame_done !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL clean_after_bubble: done=%b ready=%b expected 0/1", o_frame_done, o_ready);
    end
    for (int a = 0; a < AC; a++) read_check(AW'(a), DW'(a + 1), "clean_read");
  endtask

  task automatic test_mismatch();
    send_frame(1, 9, 3, 0);
    drive_cycle(1'b0, 32'd0);
    check_verdict(1'b0, 3'd2, 8'd2, "mismatch_verdict");
    read_check(2'd1, 32'd9, "mismatch_read1");
    send_frame(1, 2, 3, 4);
    drive_cycle(1'b0, 32'd0);
    check_verdict(1'b1, 3'd0, 8'd3, "mismatch_recover");
  endtask

  task automatic test_gapped();
    send_frame(5, 6, 7, 8);
    drive_cycle(1'b0, 32'd0);
    drive_cycle(1'b1, 32'd1);
    drive_cycle(1'b0, 32'hDEAD_0001);
    drive_cycle(1'b0, 32'hDEAD_0002);
    drive_cycle(1'b1, 32'd2);
    drive_cycle(1'b0, 32'hDEAD_0003);
    drive_cycle(1'b1, 32'd3);
    drive_cycle(1'b1, 32'd4);
    i_valid = 1'b0;
    checks++;
    if (o_frame_done !== 1'b1) begin
      errors++;
      $display("FAIL gapped_done: done=%b expected 1", o_frame_done);
    end
    for (int a = 0; a < AC; a++) read_check(AW'(a), DW'(a + 1), "gapped_read");
  endtask

  task automatic test_read_before_write();
    logic [DW-1:0] old;
    for (int k = 0; k < AC; k++) begin
      i_raddr = AW'(m_wptr);
      old     = m_mem[m_wptr];
      send_word(DW'(k + 1));
      checks++;
      if (o_rdata !== old) begin
        errors++;
        $display("FAIL read_before_write: rdata got %h expected old %h", o_rdata, old);
      end
    end
    i_valid = 1'b0;
    drive_cycle(1'b0, 32'd0);
    for (int a = 0; a < AC; a++) read_check(AW'(a), DW'(a + 1), "rbw_read_new");
  endtask

  task automatic test_held_valid();
    send_word(7);
    send_word(2);
    send_word(3);
    send_word(4);
    // Valid stays high with word 1 through the DONE bubble.
    send_word(1);
    i_valid = 1'b0;
    checks++;
    if (m_wptr != 1) begin
      errors++;
      $display("FAIL held_model_wptr: got %0d expected 1", m_wptr);
    end
    read_check(2'd0, 32'd1, "held_gpr0");
    send_word(2);
    send_word(3);
    send_word(4);
    i_valid = 1'b0;
    drive_cycle(1'b0, 32'd0);
    check_verdict(1'b1, 3'd0, m_fcnt, "held_frame_verdict");
  endtask

  task automatic test_mid_reset();
    int p0;
    send_word(1);
    send_word(2);
    i_valid = 1'b0;
    p0 = pulses;
    apply_reset(1);
    check_all_zero("midreset_outputs");
    read_check(2'd0, 32'd0, "midreset_gpr0");
    read_check(2'd1, 32'd0, "midreset_gpr1");
    checks++;
    if (pulses != p0) begin
      errors++;
      $display("FAIL midreset_no_done: pulses got %0d expected %0d", pulses, p0);
    end
    send_frame(1, 2, 3, 4);
    drive_cycle(1'b0, 32'd0);
    check_verdict(1'b1, 3'd0, 8'd1, "midreset_new_frame");
  endtask

  task automatic test_wrap();
    int p0;
    p0 = pulses;
    saw_wrap = 1'b0;
    for (int f = 0; f < 256; f++) send_frame(1, 2, 3, 4);
    drive_cycle(1'b0, 32'd0);
    checks++;
    if (pulses - p0 != 256) begin
      errors++;
      $display("FAIL wrap_pulses: got %0d expected 256", pulses - p0);
    end
    checks++;
    if (saw_wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap_255_to_0: transition not observed");
    end
    check_verdict(1'b1, 3'd0, 8'd1, "wrap_final_count");
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_raddr = '0;
    model_reset();

    test_reset();
    test_clean();
    test_mismatch();
    test_gapped();
    test_read_before_write();
    test_held_valid();
    test_mid_reset();
    test_wrap();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d verdicts left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
